// File: rtl/lfsr_tick_seq_if.sv
// Control/status bundle between the divided-clock LFSR stepper and its driver.
// The master drives div_clk and the controls; the slave (the stepper) returns the LFSR status.
interface lfsr_tick_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             div_clk;
  logic             start;
  logic             stop;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] q;
  logic             running;
  logic [CNT_W-1:0] step_count;
  logic [CNT_W-1:0] period_len;
  logic             period_done;
  logic             err;

  modport master (
    output div_clk, start, stop, load, seed,
    input  q, running, step_count, period_len, period_done, err
  );

  modport slave (
    input  div_clk, start, stop, load, seed,
    output q, running, step_count, period_len, period_done, err
  );
endinterface

// File: rtl/lfsr_tick_seq.sv
// Fibonacci LFSR stepped once per rising edge of a slow div_clk sampled in the clk domain,
// with seed load, run/stop control, period measurement and lock-up detection.
module lfsr_tick_seq #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
  parameter logic [WIDTH-1:0] RST_SEED = 8'h01,
  parameter int               CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  lfsr_tick_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;

  state_t           state;
  logic [2:0]       sync_pipe;  // [0]=s1, [1]=s2, [2]=s3 (previous s2)
  logic             tick;
  logic [WIDTH-1:0] q, seed_reg, q_next;
  logic [CNT_W-1:0] step_count, period_len, cnt_inc;
  logic             running, period_done, err, fb;

  wire rise = sync_pipe[1] & ~sync_pipe[2];

  always_comb begin
    fb = 1'b0;
    for (int i = 0; i < WIDTH; i++) fb = fb ^ (q[i] & TAPS[i]);
    q_next  = {q[WIDTH-2:0], fb};
    cnt_inc = (&step_count) ? step_count : step_count + CNT_W'(1);
  end

  // Rise detect is registered once more so the step lands three clocks after div_clk is first seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sync_pipe   <= '0;
      tick        <= 1'b0;
      q           <= RST_SEED;
      seed_reg    <= RST_SEED;
      step_count  <= '0;
      period_len  <= '0;
      running     <= 1'b0;
      period_done <= 1'b0;
      err         <= 1'b0;
    end else begin
      sync_pipe   <= {sync_pipe[1:0], bus.div_clk};
      tick        <= rise;
      period_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.stop) begin
            if (bus.load) begin
              if (bus.seed != '0) begin
                q          <= bus.seed;
                seed_reg   <= bus.seed;
                step_count <= '0;
              end else begin
                state <= ERROR;
                err   <= 1'b1;
              end
            end else if (bus.start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (q == '0) begin
            state   <= ERROR;
            running <= 1'b0;
            err     <= 1'b1;
          end else if (tick) begin
            q <= q_next;
            if (q_next == seed_reg) begin
              period_done <= 1'b1;
              period_len  <= cnt_inc;
              step_count  <= '0;
            end else begin
              step_count  <= cnt_inc;
            end
          end
        end
        ERROR: begin
          running <= 1'b0;
          err     <= 1'b1;
        end
        default: state <= ERROR;
      endcase
    end
  end

  assign bus.q           = q;
  assign bus.running     = running;
  assign bus.step_count  = step_count;
  assign bus.period_len  = period_len;
  assign bus.period_done = period_done;
  assign bus.err         = err;
endmodule

// File: tb/tb_lfsr_tick_seq.sv
// Directed bench for lfsr_tick_seq: a vector table of control+pulse steps plus
// hand-written sequences for tick timing, stop/tick collision, wrap and mid-run reset.
module tb_lfsr_tick_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_tick_seq_if #(.WIDTH(8), .CNT_W(16)) bus ();

  lfsr_tick_seq #(.WIDTH(8), .TAPS(8'hB8), .RST_SEED(8'h01), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pd_cnt = 0;

  always @(negedge clk) if (bus.period_done === 1'b1) pd_cnt++;

  typedef struct {
    logic       start, stop, load;
    logic [7:0] seed;
    logic       pulse;
    logic [7:0] q;
    logic       run;
    logic [15:0] cnt;
    logic       err;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(logic st, logic sp, logic ld, logic [7:0] sd, logic pl,
                              logic [7:0] eq, logic er, logic [15:0] ec, logic ee);
    vec_t v;
    v.start = st; v.stop = sp; v.load = ld; v.seed = sd; v.pulse = pl;
    v.q = eq; v.run = er; v.cnt = ec; v.err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    bus.div_clk = 1'b1; step(hi);
    bus.div_clk = 1'b0; step(lo);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(1); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.div_clk = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.load = 1'b0; bus.seed = 8'h00;
    step(2);
    rst = 1'b0;
    chk("rst.q",    32'(bus.q), 32'h01);
    chk("rst.run",  32'(bus.running), 32'd0);
    chk("rst.cnt",  32'(bus.step_count), 32'd0);
    chk("rst.plen", 32'(bus.period_len), 32'd0);
    chk("rst.pd",   32'(bus.period_done), 32'd0);
    chk("rst.err",  32'(bus.err), 32'd0);

    //          start stop load seed  pulse  q     run  cnt  err
    vt[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 16'd1, 1'b0);
    vt[1]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 16'd2, 1'b0);
    vt[2]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 16'd3, 1'b0);
    vt[3]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 16'd4, 1'b0);
    vt[4]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 16'd4, 1'b0);
    vt[5]  = mk(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h5A, 1'b0, 16'd0, 1'b0);
    vt[6]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hB4, 1'b1, 16'd1, 1'b0);
    vt[7]  = mk(1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 8'h69, 1'b1, 16'd2, 1'b0);
    vt[8]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h69, 1'b0, 16'd2, 1'b0);
    vt[9]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h69, 1'b0, 16'd2, 1'b0);
    vt[10] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hD2, 1'b1, 16'd3, 1'b0);
    vt[11] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hD2, 1'b0, 16'd3, 1'b0);
    vt[12] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'hD2, 1'b0, 16'd3, 1'b1);
    vt[13] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hD2, 1'b0, 16'd3, 1'b1);

    for (int i = 0; i < 14; i++) begin
      bus.start = vt[i].start; bus.stop = vt[i].stop;
      bus.load  = vt[i].load;  bus.seed = vt[i].seed;
      step(1);
      bus.start = 1'b0; bus.stop = 1'b0; bus.load = 1'b0; bus.seed = 8'h00;
      if (vt[i].pulse) pulse(5, 5);
      else step(10);
      chk($sformatf("v%0d.q", i),   32'(bus.q), 32'(vt[i].q));
      chk($sformatf("v%0d.run", i), 32'(bus.running), 32'(vt[i].run));
      chk($sformatf("v%0d.cnt", i), 32'(bus.step_count), 32'(vt[i].cnt));
      chk($sformatf("v%0d.err", i), 32'(bus.err), 32'(vt[i].err));
    end

    // Reset leaves ERROR
    do_reset();
    chk("err_rst.q",   32'(bus.q), 32'h01);
    chk("err_rst.err", 32'(bus.err), 32'd0);

    // Stop in the same cycle as a tick: step dropped, stepping later resumes from held q
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    bus.div_clk = 1'b1; step(3);
    chk("coll.pre_q", 32'(bus.q), 32'h01);
    bus.stop = 1'b1; step(1); bus.stop = 1'b0;
    chk("coll.q",   32'(bus.q), 32'h01);
    chk("coll.run", 32'(bus.running), 32'd0);
    bus.div_clk = 1'b0; step(3);
    pulse(2, 4);
    chk("coll.idle_q", 32'(bus.q), 32'h01);
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    pulse(5, 5);
    chk("coll.resume_q", 32'(bus.q), 32'h02);

    // Full period from seed 01: predecessor of 01 is 80
    do_reset();
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    begin
      int pd0;
      pd0 = pd_cnt;
      for (int k = 0; k < 254; k++) pulse(2, 2);
      step(2);
      chk("wrap.pd_before", 32'(pd_cnt - pd0), 32'd0);
      chk("wrap.q254",      32'(bus.q), 32'h80);
      chk("wrap.cnt254",    32'(bus.step_count), 32'd254);
      pulse(2, 2); step(2);
      chk("wrap.pd1",  32'(pd_cnt - pd0), 32'd1);
      chk("wrap.q",    32'(bus.q), 32'h01);
      chk("wrap.plen", 32'(bus.period_len), 32'd255);
      chk("wrap.cnt",  32'(bus.step_count), 32'd0);
      for (int k = 0; k < 255; k++) pulse(2, 2);
      step(2);
      chk("wrap.pd2",   32'(pd_cnt - pd0), 32'd2);
      chk("wrap.q2",    32'(bus.q), 32'h01);
      chk("wrap.plen2", 32'(bus.period_len), 32'd255);
    end

    // Exact step latency, then div_clk held high still yields one step
    bus.div_clk = 1'b1; step(3);
    chk("lat.q_n2", 32'(bus.q), 32'h01);
    step(1);
    chk("lat.q_n3", 32'(bus.q), 32'h02);
    step(96);
    chk("hold.q",   32'(bus.q), 32'h02);
    chk("hold.cnt", 32'(bus.step_count), 32'd1);
    bus.div_clk = 1'b0; step(3);

    // Seed 1E steps to 3C; reset mid-pulse restores everything
    bus.stop = 1'b1; step(1); bus.stop = 1'b0;
    bus.load = 1'b1; bus.seed = 8'h1E; step(1); bus.load = 1'b0; bus.seed = 8'h00;
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    bus.div_clk = 1'b1; step(100);
    chk("mid.q3c", 32'(bus.q), 32'h3C);
    bus.div_clk = 1'b0; step(3);
    bus.div_clk = 1'b1; step(2);
    do_reset();
    chk("mid.q",    32'(bus.q), 32'h01);
    chk("mid.run",  32'(bus.running), 32'd0);
    chk("mid.cnt",  32'(bus.step_count), 32'd0);
    chk("mid.plen", 32'(bus.period_len), 32'd0);
    chk("mid.pd",   32'(bus.period_done), 32'd0);
    chk("mid.err",  32'(bus.err), 32'd0);
    step(6);
    chk("mid.idle_q", 32'(bus.q), 32'h01);
    bus.div_clk = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lfsr_tick_seq.md
Name: lfsr_tick_seq

Overview:
- Consumer stage fed by the slow divided clock output of the clock divider.
- Samples `div_clk` as a data signal in the fast `clk` domain and converts each rising edge into a one-cycle step tick.
- Advances a Fibonacci LFSR once per tick, with seed load, run/stop control, period measurement and lock-up detection.
- Outputs drive the LED/display logic.

Parameters:
- WIDTH, 8: LFSR width in bits.
- TAPS, 8'hB8: feedback tap mask. Bit i set means q[i] is XORed into the feedback. The default gives x^8+x^6+x^5+x^4+1, maximal length 255.
- RST_SEED, 8'h01: LFSR and seed register value after reset. Must be non-zero.
- CNT_W, 16: width of the step counter and the period register.

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst  input  1  reset; synchronous, active-high.
- div_clk  input  1  divided clock from the divider; treated as data and synchronised internally.
- start  input  1  level-sampled; IDLE to RUN.
- stop  input  1  level-sampled; RUN to IDLE.
- load  input  1  load `seed` into the LFSR; honoured in IDLE only.
- seed  input  WIDTH  seed value captured on `load`.
- q  output  WIDTH  current LFSR state.
- running  output  1  high in RUN.
- step_count  output  CNT_W  steps since last load or reset; saturates at all-ones.
- period_len  output  CNT_W  step count latched when the sequence returns to the seed.
- period_done  output  1  one-cycle pulse when q returns to the seed.
- err  output  1  sticky in ERROR state.

Behaviour:
- Reset (rst=1 at a posedge), which overrides everything, sets:
  - q = seed_reg = RST_SEED
  - step_count = 0, period_len = 0
  - running = 0, period_done = 0, err = 0
  - sync flops = 0, state = IDLE
- Synchroniser:
  - Two flops s1 and s2, plus a previous-value flop s3.
  - tick = s2 & ~s3, which is exactly one clk cycle per div_clk rising edge.
  - Edge N is the first posedge sampling div_clk=1. tick is high between posedges N+2 and N+3, and q updates at N+3.
  - Falling edges of div_clk produce nothing.
  - div_clk high for multiple cycles still gives one tick.
- Step function:
  - fb = XOR over i of (q[i] & TAPS[i]).
  - q_next = {q[WIDTH-2:0], fb}.
- FSM states are IDLE, RUN and ERROR. Within a cycle, priority is rst > stop > load > start > tick.
- IDLE:
  - running=0; ticks are ignored and q holds.
  - load with seed != 0: q <= seed, seed_reg <= seed, step_count <= 0. The start that same cycle is ignored.
  - load with seed == 0: go to ERROR, err <= 1, q unchanged.
  - start (no load): go to RUN.
- RUN:
  - running=1.
  - On tick: q <= q_next and step_count <= step_count+1, saturating at 2^CNT_W-1.
  - If q_next == seed_reg on a tick: period_done pulses for the following cycle, period_len <= step_count+1 (saturated), step_count <= 0, and RUN continues.
  - If q == 0 at any cycle (lock-up, possible only with a non-maximal TAPS): go to ERROR.
  - stop: go to IDLE. A tick in the same cycle as stop is dropped; q holds.
  - load is ignored in RUN.
- ERROR:
  - running=0, err=1, q holds.
  - Only rst leaves ERROR. start, stop, load and tick have no effect.
- period_done is high for exactly one cycle per wrap and never while in IDLE or ERROR.
- Ticks are not queued: a tick arriving in IDLE is lost, and RUN steps only on later ticks.
- A tick occurring in the same cycle as start (IDLE to RUN transition) is not applied.
- A mid-sequence rst returns all state to reset values on the next posedge, regardless of the sync pipeline contents.

Test Plan:
- Reset, then start. Drive div_clk high for 5 cycles then low, four times.
  - Expect q = 01 → 02 → 04 → 08 → 11 (hex) and step_count = 4.
  - Each q update lands 3 posedges after div_clk is first sampled high.
- Run 255 div_clk pulses from seed 01.
  - Expect period_done to pulse exactly once, on the 255th step, with q = 01, period_len = 255 and step_count = 0 afterwards.
  - A second 255 pulses gives a second pulse.
- In IDLE, load with seed=8'h5A, then start, then one tick.
  - Expect q = B4: fb = q7^q5^q4^q3 = 0^0^1^1 = 0.
  - Load asserted during RUN leaves q unchanged.
- Load with seed=0 in IDLE.
  - Expect err = 1, running = 0, and q unchanged.
  - Further start and tick have no effect; rst returns q = 01 and err = 0.
- Stop asserted in the same cycle as a tick.
  - Expect q unchanged and running = 0 next cycle.
  - Later ticks are ignored until start; after start, stepping resumes from the held q.
- With div_clk held high 100 cycles, expect exactly one step. Assert rst mid-sequence at q = 3C; expect all outputs at reset values the next cycle.
